frame_streamer: RTL and testbench



---
 rtl/frame_streamer_if.sv | 25 ++
 rtl/frame_streamer.sv | 182 ++++++++++++++++++
 tb/tb_frame_streamer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_streamer_if.sv
// Streaming bus of the frame streamer: synchronous-read frame memory port
// plus the (en, x, y, data) pixel stream feeding the detection pipeline.
interface frame_streamer_if #(
    parameter int ADDR_W = 19,
    parameter int LOC_W  = 11,
    parameter int PIX_W  = 24
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    logic              en;
    logic [LOC_W-1:0]  x;
    logic [LOC_W-1:0]  y;
    logic [PIX_W-1:0]  data;

    modport master (
        output mem_rd, mem_addr, en, x, y, data,
        input  mem_data
    );

    modport slave (
        input  mem_rd, mem_addr, en, x, y, data,
        output mem_data
    );
endinterface

// File: rtl/frame_streamer.sv
// Raster-scan pixel source: reads a frame row-major from synchronous memory,
// emits pixels with coordinates, optional zero tail pixels, then frame_done.
module frame_streamer #(
    parameter int FRAME_W     = 640,
    parameter int FRAME_H     = 480,
    parameter int LOC_W       = 11,
    parameter int ADDR_W      = 19,
    parameter int PIX_W       = 24,
    parameter int TAIL_PIXELS = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    frame_streamer_if.master  bus,
    output logic              busy,
    output logic              frame_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_STREAM, S_TAIL, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_W * FRAME_H - 1);
    localparam logic [LOC_W-1:0]  COL_LAST  = LOC_W'(FRAME_W - 1);
    localparam logic [LOC_W-1:0]  ROW_LAST  = LOC_W'(FRAME_H - 1);
    localparam logic [15:0]       TAIL_LAST = 16'(TAIL_PIXELS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LOC_W-1:0]   col_q, col_d, row_q, row_d;
    logic [15:0]        tail_q, tail_d;
    logic               pend_q, pend_d;
    logic [LOC_W-1:0]   pcol_q, pcol_d, prow_q, prow_d;
    logic               en_q, en_d;
    logic [LOC_W-1:0]   x_q, x_d, y_q, y_d;
    logic [PIX_W-1:0]   data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd;

    assign rd = (state_q == S_STREAM) && !stall;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        tail_d  = tail_q;
        pend_d  = rd;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        en_d    = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (rd) begin
            pcol_d = col_q;
            prow_d = row_q;
        end
        // Memory data of the read issued last cycle is valid now.
        if (pend_q) begin
            en_d   = 1'b1;
            x_d    = pcol_q;
            y_d    = prow_q;
            data_d = bus.mem_data;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    busy_d  = 1'b1;
                end
            end
            S_STREAM: begin
                if (rd) begin
                    addr_d = addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (addr_q == ADDR_LAST) begin
                        addr_d  = '0;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = (TAIL_PIXELS > 0) ? S_TAIL : S_DRAIN;
                    end
                end
            end
            S_TAIL: begin
                // Tail pixels wait for the last real pixel to leave the pipeline.
                if (!stall && !pend_q) begin
                    en_d   = 1'b1;
                    x_d    = COL_LAST;
                    y_d    = ROW_LAST;
                    data_d = '0;
                    if (tail_q == TAIL_LAST) begin
                        tail_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        tail_d = tail_q + 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!pend_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            addr_d  = '0;
            col_d   = '0;
            row_d   = '0;
            tail_d  = '0;
            pend_d  = 1'b0;
            en_d    = 1'b0;
            x_d     = x_q;
            y_d     = y_q;
            data_d  = data_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            tail_q  <= '0;
            pend_q  <= 1'b0;
            pcol_q  <= '0;
            prow_q  <= '0;
            en_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tail_q  <= tail_d;
            pend_q  <= pend_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
            en_q    <= en_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.mem_rd   = rd;
    assign bus.mem_addr = addr_q;
    assign bus.en       = en_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.data     = data_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer on a 4x3 frame: one instance without tail
// pixels and one with two, driven in lockstep.
module tb_frame_streamer;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct {
        logic [23:0] d;
        logic [3:0]  x;
        logic [3:0]  y;
        int          c;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, stall = 1'b0;
    logic busy0, done0, busy2, done2;
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;

    pix_t pix [2][256];
    int   np [2];
    int   bcnt [2];
    int   dcnt [2];
    int   dcyc [2];

    frame_streamer_if #(.ADDR_W(4), .LOC_W(4), .PIX_W(24)) b0 ();
    frame_streamer_if #(.ADDR_W(4), .LOC_W(4), .PIX_W(24)) b2 ();

    frame_streamer #(.FRAME_W(W), .FRAME_H(H), .LOC_W(4), .ADDR_W(4),
                     .PIX_W(24), .TAIL_PIXELS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .stall(stall), .bus(b0), .busy(busy0), .frame_done(done0));

    frame_streamer #(.FRAME_W(W), .FRAME_H(H), .LOC_W(4), .ADDR_W(4),
                     .PIX_W(24), .TAIL_PIXELS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .stall(stall), .bus(b2), .busy(busy2), .frame_done(done2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame memory model: word i holds 0x5A0000 + i.
    always @(posedge clk) begin
        if (b0.mem_rd) b0.mem_data <= 24'h5A0000 + 24'(b0.mem_addr);
        if (b2.mem_rd) b2.mem_data <= 24'h5A0000 + 24'(b2.mem_addr);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            np[d] = 0; bcnt[d] = 0; dcnt[d] = 0; dcyc[d] = 0;
        end
    end

    always @(negedge clk) begin
        if (b0.en && np[0] < 256) begin
            pix[0][np[0]] <= '{b0.data, b0.x, b0.y, cyc};
            np[0] <= np[0] + 1;
        end
        if (b2.en && np[1] < 256) begin
            pix[1][np[1]] <= '{b2.data, b2.x, b2.y, cyc};
            np[1] <= np[1] + 1;
        end
        if (busy0) bcnt[0] <= bcnt[0] + 1;
        if (busy2) bcnt[1] <= bcnt[1] + 1;
        if (done0) begin dcnt[0] <= dcnt[0] + 1; dcyc[0] <= cyc; end
        if (done2) begin dcnt[1] <= dcnt[1] + 1; dcyc[1] <= cyc; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int base [2], bbase [2], dbase [2];

    task automatic snap();
        for (int d = 0; d < 2; d++) begin
            base[d] = np[d]; bbase[d] = bcnt[d]; dbase[d] = dcnt[d];
        end
    endtask

    // Pulse start for one edge; returns the cycle number seen after that edge.
    task automatic pulse_start(output int ce);
        @(negedge clk);
        snap();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ce = cyc;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy0 && !busy2 && !start) begin ok = 1'b1; break; end
        end
        check("idle_timeout", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_addr(input logic [3:0] a);
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (b0.mem_rd && b0.mem_addr == a) begin ok = 1'b1; break; end
        end
        check("addr_timeout", 32'(ok), 32'd1);
    endtask

    // Full-frame check; pixels at index >= sfrom are delayed by slen stall cycles.
    task automatic check_frame(input string t, input int d, input int ce,
                               input int ntail, input int sfrom, input int slen);
        int   ec;
        pix_t p;
        check($sformatf("%s.u%0d.count", t, d), 32'(np[d] - base[d]), 32'(N + ntail));
        for (int i = 0; i < N + ntail; i++) begin
            p = pix[d][base[d] + i];
            if (i < N) begin
                ec = ce + 2 + i + ((i >= sfrom) ? slen : 0);
                check($sformatf("%s.u%0d.p%0d.data", t, d, i), 32'(p.d), 32'h5A0000 + 32'(i));
                check($sformatf("%s.u%0d.p%0d.x", t, d, i), 32'(p.x), 32'(i % W));
                check($sformatf("%s.u%0d.p%0d.y", t, d, i), 32'(p.y), 32'(i / W));
            end else begin
                ec = ce + 2 + i + slen;
                check($sformatf("%s.u%0d.t%0d.data", t, d, i), 32'(p.d), 32'd0);
                check($sformatf("%s.u%0d.t%0d.xy", t, d, i), {24'd0, p.x, p.y}, 32'h32);
            end
            check($sformatf("%s.u%0d.p%0d.cyc", t, d, i), 32'(p.c), 32'(ec));
        end
        check($sformatf("%s.u%0d.done_cnt", t, d), 32'(dcnt[d] - dbase[d]), 32'd1);
        check($sformatf("%s.u%0d.done_cyc", t, d), 32'(dcyc[d]), 32'(ce + N + 2 + slen + ntail));
        check($sformatf("%s.u%0d.busy_len", t, d), 32'(bcnt[d] - bbase[d]), 32'(N + 3 + slen + ntail));
    endtask

    initial begin
        int ce;
        // Reset state
        @(negedge clk);
        check("rst.en", 32'(b0.en), 32'd0);
        check("rst.xy", {24'd0, b0.x, b0.y}, 32'd0);
        check("rst.data", 32'(b0.data), 32'd0);
        check("rst.busy", 32'(busy0), 32'd0);
        check("rst.done", 32'(done0), 32'd0);
        check("rst.mem_rd", 32'(b0.mem_rd), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain frame (and two tail pixels on the second instance)
        pulse_start(ce);
        check("t1.busy_rise", 32'(busy0), 32'd1);
        check("t1.first_rd", {27'd0, b0.mem_rd, b0.mem_addr}, 32'h10);
        wait_idle();
        check_frame("t1", 0, ce, 0, 99, 0);
        check_frame("t3", 1, ce, 2, 99, 0);

        // Stall for three cycles from the cycle where address 5 is presented
        pulse_start(ce);
        wait_addr(4'd5);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        wait_idle();
        check_frame("t2", 0, ce, 0, 5, 3);
        check_frame("t2", 1, ce, 2, 5, 3);

        // Abort while address 7 is presented
        pulse_start(ce);
        wait_addr(4'd7);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4.en_after_abort", 32'(b0.en), 32'd0);
        check("t4.busy_after_abort", 32'(busy0), 32'd0);
        check("t4.rd_after_abort", 32'(b0.mem_rd), 32'd0);
        repeat (4) @(negedge clk);
        check("t4.pix_count", 32'(np[0] - base[0]), 32'd6);
        check("t4.no_done", 32'(dcnt[0] - dbase[0]), 32'd0);
        check("t4.no_done_tail", 32'(dcnt[1] - dbase[1]), 32'd0);
        // start together with abort in IDLE must not start a frame
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t4.abort_wins_busy", 32'(busy0), 32'd0);
        check("t4.abort_wins_rd", 32'(b0.mem_rd), 32'd0);
        pulse_start(ce);
        wait_idle();
        check_frame("t4r", 0, ce, 0, 99, 0);

        // start held high across a whole frame
        @(negedge clk);
        snap();
        start = 1'b1;
        @(negedge clk);
        ce = cyc;
        begin
            bit ok = 1'b0;
            for (int k = 0; k < 60; k++) begin
                if (done0) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            check("t5.done_seen", 32'(ok), 32'd1);
        end
        check("t5.done_cyc", 32'(cyc), 32'(ce + N + 2));
        check("t5.busy_at_done", 32'(busy0), 32'd1);
        @(negedge clk);
        check("t5.idle_gap", 32'(busy0), 32'd0);
        @(negedge clk);
        check("t5.restart_busy", 32'(busy0), 32'd1);
        check("t5.restart_rd", {27'd0, b0.mem_rd, b0.mem_addr}, 32'h10);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-stream
        pulse_start(ce);
        wait_addr(4'd4);
        #1 reset_n = 1'b0;
        #1;
        check("t6.en_async", 32'(b0.en), 32'd0);
        check("t6.busy_async", 32'(busy0), 32'd0);
        check("t6.rd_async", 32'(b0.mem_rd), 32'd0);
        check("t6.xy_async", {24'd0, b0.x, b0.y}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start(ce);
        wait_idle();
        check_frame("t6", 0, ce, 0, 99, 0);
        check_frame("t6", 1, ce, 2, 99, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
